// File: rtl/accel_tilt_tracker.sv
// accel_tilt_tracker: turns accelerometer X/Y tilt into a clamped 2-D cursor
// position. Once per tick it captures both axes, filters them with a 4-tap
// moving average and a dead-zone, then integrates a scaled velocity into the
// position with saturation at the screen edges.
//
// Build option: define TRACK_Y_INVERT_EN to negate the Y velocity so that
// positive Y acceleration moves the cursor towards row 0 (top of screen).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for the tick counter terminal count
// S_CAPTURE | saturate both axes and shift them into the history
// S_FILTER  | average/dead-zone the history; new position is registered
//           | on the edge that leaves this state
// S_UPDATE  | oVALID high, outputs hold the new position; back to idle
module accel_tilt_tracker #(
    parameter int TICK_DIV  = 500000,
    parameter int X_MAX     = 639,
    parameter int Y_MAX     = 479,
    parameter int DEADZONE  = 8,
    parameter int VEL_SHIFT = 5
) (
    input  logic       iSPI_CLK,
    input  logic       iRSTN,
    input  logic [7:0] iX_L,
    input  logic [7:0] iX_H,
    input  logic [7:0] iY_L,
    input  logic [7:0] iY_H,
    input  logic       iRECENTER,
    output logic [9:0] oX_POS,
    output logic [8:0] oY_POS,
    output logic       oVALID,
    output logic [1:0] oSAT
);

    localparam int CW = $clog2(TICK_DIV);

    localparam logic [9:0]         X_CTR  = 10'(X_MAX / 2 + 1);
    localparam logic [8:0]         Y_CTR  = 9'(Y_MAX / 2 + 1);
    localparam logic [9:0]         X_LIM  = 10'(X_MAX);
    localparam logic [8:0]         Y_LIM  = 9'(Y_MAX);
    localparam logic signed [11:0] X_LIM_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_LIM_S = 12'(Y_MAX);
    localparam logic signed [10:0] DZ     = 11'(DEADZONE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_FILTER  = 2'd2,
        S_UPDATE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0] tick_q, tick_d;
    logic          tick_tc;

    logic signed [9:0] hx_q [4];
    logic signed [9:0] hy_q [4];
    logic [2:0]        nsamp_q;

    logic [9:0] x_q, x_d;
    logic [8:0] y_q, y_d;
    logic [1:0] sat_q, sat_d;
    logic       valid_q;

    logic capture_en;
    logic update_en;

    logic signed [9:0]  sx, sy;
    logic signed [9:0]  ax, ay;
    logic signed [9:0]  vx, vy, vy_eff;
    logic signed [11:0] px_next, py_next;

    // Clip a raw 16-bit two's complement reading to the 10-bit range [-512, 511].
    function automatic logic signed [9:0] sat10(input logic [15:0] raw);
        logic signed [15:0] v;
        v = signed'(raw);
        if (v > 16'sd511) begin
            return 10'sd511;
        end else if (v < -16'sd512) begin
            return -10'sd512;
        end else begin
            return v[9:0];
        end
    endfunction

    // Moving average once the history is full, otherwise the newest sample;
    // small magnitudes are then squashed to zero by the dead-zone.
    function automatic logic signed [9:0] filt(
        input logic signed [9:0] h0,
        input logic signed [9:0] h1,
        input logic signed [9:0] h2,
        input logic signed [9:0] h3,
        input logic [2:0]        n
    );
        logic signed [11:0] sum;
        logic signed [11:0] q;
        logic signed [9:0]  avg;
        logic signed [10:0] a11;
        sum = {{2{h0[9]}}, h0} + {{2{h1[9]}}, h1} + {{2{h2[9]}}, h2} + {{2{h3[9]}}, h3};
        q   = sum >>> 2;
        if (n == 3'd4) begin
            avg = q[9:0];
        end else begin
            avg = h0;
        end
        a11 = {avg[9], avg};
        if ((a11 < DZ) && (a11 > -DZ)) begin
            avg = '0;
        end
        return avg;
    endfunction

    // Free-running tick counter, restarted by recenter.
    always_comb begin
        tick_tc = (tick_q == CW'(TICK_DIV - 1));
        tick_d  = tick_q + CW'(1);
        if (iRECENTER || tick_tc) begin
            tick_d = '0;
        end
    end

    // Tick counter register.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

    // FSM state register.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; recenter forces idle from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (tick_tc) state_d = S_CAPTURE;
            S_CAPTURE: state_d = S_FILTER;
            S_FILTER:  state_d = S_UPDATE;
            S_UPDATE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        if (iRECENTER) begin
            state_d = S_IDLE;
        end
    end

    // FSM output decode: datapath enables.
    always_comb begin
        capture_en = 1'b0;
        update_en  = 1'b0;
        case (state_q)
            S_CAPTURE: capture_en = 1'b1;
            S_FILTER:  update_en  = 1'b1;
            default: begin
                capture_en = 1'b0;
                update_en  = 1'b0;
            end
        endcase
    end

    // Filter, velocity and clamped position for both axes.
    always_comb begin
        sx = sat10({iX_H, iX_L});
        sy = sat10({iY_H, iY_L});
        ax = filt(hx_q[0], hx_q[1], hx_q[2], hx_q[3], nsamp_q);
        ay = filt(hy_q[0], hy_q[1], hy_q[2], hy_q[3], nsamp_q);
        vx = ax >>> VEL_SHIFT;
        vy = ay >>> VEL_SHIFT;
`ifdef TRACK_Y_INVERT_EN
        vy_eff = -vy;
`else
        vy_eff = vy;
`endif
        px_next = signed'({2'b00, x_q}) + {{2{vx[9]}}, vx};
        py_next = signed'({3'b000, y_q}) + {{2{vy_eff[9]}}, vy_eff};

        x_d      = px_next[9:0];
        sat_d[0] = 1'b0;
        if (px_next < 12'sd0) begin
            x_d      = '0;
            sat_d[0] = 1'b1;
        end else if (px_next > X_LIM_S) begin
            x_d      = X_LIM;
            sat_d[0] = 1'b1;
        end

        y_d      = py_next[8:0];
        sat_d[1] = 1'b0;
        if (py_next < 12'sd0) begin
            y_d      = '0;
            sat_d[1] = 1'b1;
        end else if (py_next > Y_LIM_S) begin
            y_d      = Y_LIM;
            sat_d[1] = 1'b1;
        end
    end

    // History, sample count, position and status registers.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            for (int i = 0; i < 4; i++) begin
                hx_q[i] <= '0;
                hy_q[i] <= '0;
            end
            nsamp_q <= '0;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            sat_q   <= '0;
            valid_q <= 1'b0;
        end else if (iRECENTER) begin
            for (int i = 0; i < 4; i++) begin
                hx_q[i] <= '0;
                hy_q[i] <= '0;
            end
            nsamp_q <= '0;
            x_q     <= X_CTR;
            y_q     <= Y_CTR;
            sat_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= update_en;
            if (capture_en) begin
                hx_q[0] <= sx;
                hy_q[0] <= sy;
                for (int i = 1; i < 4; i++) begin
                    hx_q[i] <= hx_q[i-1];
                    hy_q[i] <= hy_q[i-1];
                end
                if (nsamp_q != 3'd4) begin
                    nsamp_q <= nsamp_q + 3'd1;
                end
            end
            if (update_en) begin
                x_q   <= x_d;
                y_q   <= y_d;
                sat_q <= sat_d;
            end
        end
    end

    assign oX_POS = x_q;
    assign oY_POS = y_q;
    assign oSAT   = sat_q;
    assign oVALID = valid_q;

endmodule

// File: tb/tb_accel_tilt_tracker.sv
// Directed bench for accel_tilt_tracker with a 16-cycle tick.
module tb_accel_tilt_tracker;

    localparam int TICK_DIV = 16;
`ifdef TRACK_Y_INVERT_EN
    localparam int YS = -1;
`else
    localparam int YS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] x_l, x_h, y_l, y_h;
    logic       recenter;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       vld;
    logic [1:0] sat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accel_tilt_tracker #(
        .TICK_DIV  (TICK_DIV),
        .X_MAX     (639),
        .Y_MAX     (479),
        .DEADZONE  (8),
        .VEL_SHIFT (5)
    ) dut (
        .iSPI_CLK  (clk),
        .iRSTN     (rst_n),
        .iX_L      (x_l),
        .iX_H      (x_h),
        .iY_L      (y_l),
        .iY_H      (y_h),
        .iRECENTER (recenter),
        .oX_POS    (x_pos),
        .oY_POS    (y_pos),
        .oVALID    (vld),
        .oSAT      (sat)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_x(input logic [15:0] v);
        {x_h, x_l} = v;
    endtask

    task automatic set_y(input logic [15:0] v);
        {y_h, y_l} = v;
    endtask

    task automatic expect_pos(input string tag, input int ex, input int ey, input int es);
        chk({tag, "_x"}, int'(x_pos), ex);
        chk({tag, "_y"}, int'(y_pos), ey);
        chk({tag, "_sat"}, int'(sat), es);
    endtask

    // Bounded wait for the next oVALID strobe, sampled on the falling edge.
    task automatic wait_upd();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!vld && n < 40);
        chk("upd_seen", int'(vld), 1);
    endtask

    task automatic do_recenter();
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        expect_pos("recenter", 320, 240, 0);
        chk("recenter_vld", int'(vld), 0);
    endtask

    initial begin
        int k;
        int exp_x;
        int quiet;
        rst_n    = 1'b1;
        recenter = 1'b0;
        set_x(16'h0000);
        set_y(16'h0000);
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        expect_pos("reset", 320, 240, 0);
        chk("reset_vld", int'(vld), 0);
        rst_n = 1'b1;

        // first update: terminal count after edge 15, outputs change at edge 18
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!vld && k < 40);
        chk("first_upd_cycle", k, 18);
        expect_pos("idle_upd1", 320, 240, 0);
        @(negedge clk);
        chk("vld_width", int'(vld), 0);
        k = 1;
        do begin
            @(negedge clk);
            k++;
        end while (!vld && k < 40);
        chk("upd_period", k, TICK_DIV);
        expect_pos("idle_upd2", 320, 240, 0);

        // +256 on X: +8 per update
        do_recenter();
        set_x(16'h0100);
        for (int i = 1; i <= 5; i++) begin
            wait_upd();
            expect_pos("x_pos256", 320 + 8 * i, 240, 0);
        end

        // -256 on Y
        set_x(16'h0000);
        do_recenter();
        set_y(16'hFF00);
        for (int i = 1; i <= 3; i++) begin
            wait_upd();
            expect_pos("y_neg256", 320, 240 - YS * 8 * i, 0);
        end
        set_y(16'h0000);

        // dead-zone boundary: 5 and -7 squashed, -8 passes and floors to -1
        do_recenter();
        set_x(16'h0005);
        wait_upd();
        expect_pos("dz_5", 320, 240, 0);
        set_x(16'hFFF9);
        wait_upd();
        expect_pos("dz_m7", 320, 240, 0);
        set_x(16'hFFF8);
        wait_upd();
        expect_pos("dz_m8", 319, 240, 0);

        // input saturation at the negative end: -32768 -> -512 -> -16
        do_recenter();
        set_x(16'h8000);
        wait_upd();
        expect_pos("sat_neg", 304, 240, 0);

        // averaging: three -256 then +256 -> avg -128, vel -4
        do_recenter();
        set_x(16'hFF00);
        for (int i = 1; i <= 3; i++) begin
            wait_upd();
            expect_pos("avg_neg", 320 - 8 * i, 240, 0);
        end
        set_x(16'h0100);
        wait_upd();
        expect_pos("avg_mix", 292, 240, 0);

        // 0x7FFF saturates to 511 -> +15; climb to 500, then recenter in FILTER
        do_recenter();
        set_x(16'h7FFF);
        for (int i = 1; i <= 12; i++) begin
            wait_upd();
            expect_pos("x_big", 320 + 15 * i, 240, 0);
        end
        repeat (15) @(negedge clk);
        recenter = 1'b1;
        set_x(16'hFF00);
        @(negedge clk);
        recenter = 1'b0;
        expect_pos("rc_filter", 320, 240, 0);
        chk("rc_filter_vld", int'(vld), 0);
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (vld) quiet++;
        end
        chk("rc_no_vld", quiet, 0);
        wait_upd();
        expect_pos("rc_newest", 312, 240, 0);

        // clamp at X_MAX, then walk down to 0
        do_recenter();
        set_x(16'h01FF);
        for (int i = 1; i <= 21; i++) begin
            wait_upd();
            expect_pos("clamp_up", 320 + 15 * i, 240, 0);
        end
        wait_upd();
        expect_pos("clamp_hi1", 639, 240, 1);
        wait_upd();
        expect_pos("clamp_hi2", 639, 240, 1);
        set_x(16'hFF00);
        // history mixes in: avg 319 -> +9, 127 -> +3, -65 -> -3, -256 -> -8
        wait_upd();
        expect_pos("mix1", 639, 240, 1);
        wait_upd();
        expect_pos("mix2", 639, 240, 1);
        wait_upd();
        expect_pos("mix3", 636, 240, 0);
        wait_upd();
        expect_pos("mix4", 628, 240, 0);
        exp_x = 628;
        while (exp_x >= 8) begin
            exp_x -= 8;
            wait_upd();
            expect_pos("walk_down", exp_x, 240, 0);
        end
        wait_upd();
        expect_pos("clamp_lo1", 0, 240, 1);
        wait_upd();
        expect_pos("clamp_lo2", 0, 240, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
